// File: rtl/result_fifo_drain.sv
// Result buffer behind the controller's fifo_command interface: stores pushed result
// words and streams them to the external reader under MEM_READ on a drain command.
module result_fifo_drain #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            fifo_command,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  MEM_READ,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic                  drain_done,
   output logic                  busy,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  empty,
   output logic                  overflow,
   output logic [1:0]            state_dbg
);

   // Output handshake: a word moves on a rising edge where out_valid && MEM_READ;
   // out_data/out_valid never change while out_valid is high and MEM_READ is low.
   typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, FINISH = 2'd2} state_t;

   localparam logic [1:0]          CMD_WRITE = 2'b10;
   localparam logic [1:0]          CMD_READ  = 2'b01;
   localparam logic [1:0]          CMD_CLEAR = 2'b11;
   localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   wr_ptr;
   logic [ADDR_WIDTH-1:0]   rd_ptr;
   logic [1:0]              prev_cmd;
   logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

   logic push_req;
   logic drain_start;
   logic accept;
   logic do_write;

   assign push_req    = (fifo_command == CMD_WRITE);
   assign drain_start = (fifo_command == CMD_READ) && (prev_cmd != CMD_READ);
   assign accept      = out_valid && MEM_READ;
   assign do_write    = (state == IDLE) && push_req && !full;

   assign full      = (count == DEPTH_CNT);
   assign empty     = (count == '0);
   assign state_dbg = state;

   // Storage is deliberately left out of reset so it can map onto a RAM.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         drain_done <= 1'b0;
         busy       <= 1'b0;
         overflow   <= 1'b0;
         prev_cmd   <= 2'b00;
      end else begin
         prev_cmd   <= fifo_command;
         drain_done <= 1'b0;
         if (fifo_command == CMD_CLEAR) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (push_req) begin
                     if (!full) begin
                        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                        count  <= count + (ADDR_WIDTH+1)'(1);
                     end else begin
                        overflow <= 1'b1;
                     end
                  end else if (drain_start) begin
                     busy <= 1'b1;
                     if (!empty) begin
                        out_data  <= mem[rd_ptr];
                        rd_ptr    <= rd_ptr + ADDR_WIDTH'(1);
                        count     <= count - (ADDR_WIDTH+1)'(1);
                        out_valid <= 1'b1;
                        state     <= DRAIN;
                     end else begin
                        state <= FINISH;
                     end
                  end
               end
               DRAIN: begin
                  if (push_req) begin
                     overflow <= 1'b1;
                  end
                  // Refill straight from storage on acceptance to sustain 1 word/cycle.
                  if (accept) begin
                     if (!empty) begin
                        out_data <= mem[rd_ptr];
                        rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
                        count    <= count - (ADDR_WIDTH+1)'(1);
                     end else begin
                        out_valid <= 1'b0;
                        state     <= FINISH;
                     end
                  end
               end
               FINISH: begin
                  if (push_req) begin
                     overflow <= 1'b1;
                  end
                  drain_done <= 1'b1;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_result_fifo_drain.sv
// Self-checking bench for result_fifo_drain: queue-based reference model, expected
// output queue, and an independent monitor that checks every accepted word.
module tb_result_fifo_drain;

   localparam int DW    = 16;
   localparam int DEPTH = 256;
   localparam int AW    = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [1:0]    fifo_command = 2'b00;
   logic [DW-1:0] wr_data = '0;
   logic          MEM_READ = 1'b1;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          drain_done;
   logic          busy;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          overflow;
   logic [1:0]    state_dbg;

   result_fifo_drain #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .fifo_command(fifo_command), .wr_data(wr_data),
      .MEM_READ(MEM_READ), .out_data(out_data), .out_valid(out_valid),
      .drain_done(drain_done), .busy(busy), .count(count), .full(full),
      .empty(empty), .overflow(overflow), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int vec_cnt = 0;
   int err_cnt = 0;

   // Reference model: words stored but not yet drained, and words expected on the output.
   logic [DW-1:0] model_q[$];
   logic [DW-1:0] exp_q[$];
   bit            exp_ovf = 0;
   int            wr_ptr_m = 0;
   int            rd_ptr_m = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops one expected word per accepted transfer, and checks stall hold.
   bit            hold_pend = 0;
   logic [DW-1:0] hold_val = '0;
   always @(negedge clk) begin
      if (!reset) begin
         hold_pend = 0;
      end else begin
         if (hold_pend) begin
            check("stall_hold_data", out_data, hold_val);
            check("stall_hold_valid", out_valid, 1);
         end
         if (out_valid && MEM_READ) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", out_data, 32'hDEAD_0000);
            end else begin
               check("out_data", out_data, exp_q.pop_front());
            end
         end
         hold_pend = out_valid && !MEM_READ;
         hold_val  = out_data;
      end
   end

   function automatic logic mem_bit(input int mode, input int k);
      logic pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      if (mode == 1) return logic'($urandom_range(0, 1));
      if (mode == 2 && k >= 1 && k <= 5) return pat[k-1];
      return 1'b1;
   endfunction

   task automatic model_reset();
      model_q.delete();
      exp_q.delete();
      exp_ovf  = 0;
      wr_ptr_m = 0;
      rd_ptr_m = 0;
   endtask

   task automatic push(input logic [DW-1:0] w);
      fifo_command = 2'b10;
      wr_data      = w;
      @(posedge clk); #1;
      fifo_command = 2'b00;
      if (model_q.size() < DEPTH) begin
         model_q.push_back(w);
         wr_ptr_m = (wr_ptr_m + 1) % DEPTH;
      end else begin
         exp_ovf = 1;
      end
   endtask

   task automatic clear_cmd();
      fifo_command = 2'b11;
      @(posedge clk); #1;
      fifo_command = 2'b00;
      model_reset();
      check("clear_count", count, 0);
      check("clear_empty", empty, 1);
      check("clear_overflow", overflow, 0);
      check("clear_out_valid", out_valid, 0);
   endtask

   // Starts a drain (01 held for 'hold' edges) and runs it to completion.
   // mode: 0 reader always ready, 1 random backpressure, 2 fixed 1,0,0,1,1 pattern.
   task automatic drain(input int mode, input int hold, input bit inject);
      int n       = model_q.size();
      int k       = 1;
      int pulses  = 0;
      int pulse_k = 0;
      int budget  = 4 * n + hold + 40;
      while (model_q.size() > 0) exp_q.push_back(model_q.pop_front());
      rd_ptr_m = (rd_ptr_m + n) % DEPTH;
      fifo_command = 2'b01;
      MEM_READ     = mem_bit(mode, 0);
      @(posedge clk); #1;
      check("start_out_valid", out_valid, (n > 0) ? 1 : 0);
      check("start_busy", busy, 1);
      while (k < budget && !(pulses > 0 && k >= hold + 2)) begin
         if (k + 1 <= hold) begin
            fifo_command = 2'b01;
         end else if (inject && exp_q.size() > 0 && $urandom_range(0, 7) == 0) begin
            fifo_command = 2'b10;
            wr_data      = DW'($urandom);
            exp_ovf      = 1;
         end else begin
            fifo_command = 2'b00;
         end
         MEM_READ = mem_bit(mode, k);
         @(posedge clk); #1;
         k++;
         if (n == 0) check("empty_drain_no_valid", out_valid, 0);
         if (drain_done) begin
            pulses++;
            if (pulse_k == 0) pulse_k = k;
            check("done_busy_low", busy, 0);
         end else if (pulses == 0) begin
            check("busy_while_draining", busy, 1);
         end
      end
      fifo_command = 2'b00;
      MEM_READ     = 1'b1;
      if (pulses == 0) check("drain_timeout", 0, 1);
      check("drain_done_pulses", pulses, 1);
      if (mode == 0) check("drain_done_latency", pulse_k, n + 2);
      check("all_words_delivered", exp_q.size(), 0);
      check("post_drain_count", count, 0);
      check("post_drain_empty", empty, 1);
      check("post_drain_busy", busy, 0);
      check("post_drain_overflow", overflow, exp_ovf);
      exp_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_busy", busy, 0);
      check("rst_drain_done", drain_done, 0);
      check("rst_overflow", overflow, 0);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;

      // Basic in-order drain with the reader always ready.
      push(16'h0011); push(16'h0022); push(16'h0033); push(16'h0044);
      check("four_count", count, 4);
      drain(0, 1, 0);

      // Backpressure pattern on a three-word drain.
      push(16'h0A01); push(16'h0A02); push(16'h0A03);
      drain(2, 1, 0);

      // Fill to capacity, drop one push, drain the first DEPTH words.
      for (int i = 0; i < DEPTH; i++) push(DW'(i));
      check("full_after_depth", full, 1);
      check("count_at_depth", count, DEPTH);
      check("no_overflow_yet", overflow, 0);
      push(DW'(DEPTH));
      check("overflow_on_drop", overflow, 1);
      check("count_after_drop", count, DEPTH);
      drain(0, 1, 0);
      clear_cmd();

      // Drain on empty with 01 held for five cycles.
      drain(0, 5, 0);
      clear_cmd();

      // Pointer wrap-around.
      for (int i = 0; i < 200; i++) push(DW'(16'h1000 + i));
      drain(1, 1, 0);
      for (int i = 0; i < 100; i++) push(DW'(16'h3000 + i));
      drain(1, 1, 0);
      check("wrap_wr_ptr", dut.wr_ptr, wr_ptr_m);
      check("wrap_rd_ptr", dut.rd_ptr, rd_ptr_m);
      check("wrap_ptr_44", wr_ptr_m, 44);

      // Randomized traffic with backpressure and pushes injected mid-drain.
      for (int it = 0; it < 8; it++) begin
         int n = $urandom_range(0, 40);
         for (int i = 0; i < n; i++) begin
            push(DW'($urandom));
            if ($urandom_range(0, 3) == 0) begin
               @(posedge clk); #1;
            end
         end
         check("rand_count", count, model_q.size());
         drain(1, $urandom_range(1, 3), 1);
      end
      clear_cmd();

      // Asynchronous reset in the middle of a drain.
      for (int i = 0; i < 12; i++) push(DW'($urandom));
      exp_q.push_back(model_q[0]);
      fifo_command = 2'b01;
      MEM_READ     = 1'b1;
      @(posedge clk); #1;
      fifo_command = 2'b00;
      @(posedge clk); #1;
      check("mid_drain_count", count, 10);
      #2 reset = 1'b0;
      #1;
      check("async_rst_out_valid", out_valid, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_count", count, 0);
      check("async_rst_empty", empty, 1);
      model_reset();
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      drain(0, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
